// File: rtl/vmicro16_id_ex.sv
// vmicro16 ID/EX pipeline stage: combinational regfile addressing and opcode
// decode, plus the ID/EX register bank with stall (hold) and branch flush.
module vmicro16_id_ex (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] ifid_pc,
  input  logic [15:0] ifid_instr,
  input  logic        ifid_valid,
  output logic [2:0]  reg_rs1,
  output logic [2:0]  reg_rs2,
  input  logic [15:0] reg_rd1,
  input  logic [15:0] reg_rd2,
  input  logic        stall,
  input  logic        jmping,
  output logic [15:0] idex_pc,
  output logic [15:0] idex_instr,
  output logic [15:0] idex_rd1,
  output logic [15:0] idex_rd2,
  output logic [15:0] idex_rd3,
  output logic [2:0]  idex_rs1,
  output logic [2:0]  idex_rs2,
  output logic        idex_has_br,
  output logic        idex_has_we,
  output logic        idex_has_mem,
  output logic        idex_has_mem_we,
  output logic        idex_valid,
  output logic [4:0]  exme_op
);

  typedef enum logic [4:0] {
    OP_NOP  = 5'h00,
    OP_LW   = 5'h01,
    OP_SW   = 5'h02,
    OP_MOV  = 5'h03,
    OP_MOVI = 5'h04,
    OP_ALU  = 5'h05,
    OP_ADDI = 5'h06,
    OP_CMP  = 5'h07,
    OP_BR   = 5'h08
  } opcode_e;

  typedef struct packed {
    logic br;
    logic we;
    logic mem;
    logic mem_we;
  } flags_t;

  logic [4:0]  w_op;
  logic [15:0] w_sext8;
  logic [15:0] w_sext5;
  logic [15:0] w_zext8;
  logic [15:0] w_zext5;
  logic [15:0] w_rd3;
  flags_t      w_flags;
  flags_t      w_flags_valid;
  flags_t      r_flags;

  assign w_op    = ifid_instr[15:11];
  assign reg_rs1 = ifid_instr[10:8];
  assign reg_rs2 = ifid_instr[7:5];

  assign w_sext8 = {{8{ifid_instr[7]}}, ifid_instr[7:0]};
  assign w_sext5 = {{11{ifid_instr[4]}}, ifid_instr[4:0]};
  assign w_zext8 = {8'h00, ifid_instr[7:0]};
  assign w_zext5 = {11'h000, ifid_instr[4:0]};

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_flags = '0;
    w_rd3   = w_sext8;
    case (opcode_e'(w_op))
      OP_LW: begin
        w_flags.we  = 1'b1;
        w_flags.mem = 1'b1;
        w_rd3       = w_sext5;
      end
      OP_SW: begin
        w_flags.mem    = 1'b1;
        w_flags.mem_we = 1'b1;
        w_rd3          = w_sext5;
      end
      OP_MOV, OP_MOVI, OP_ADDI: w_flags.we = 1'b1;
      OP_ALU: begin
        w_flags.we = 1'b1;
        w_rd3      = w_zext5;
      end
      OP_BR: begin
        w_flags.br = 1'b1;
        w_rd3      = w_zext8;
      end
      default: ;
    endcase
  end

  // A bubble in IF/ID must never carry side effects into EX.
  assign w_flags_valid = ifid_valid ? w_flags : '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idex_pc    <= '0;
      idex_instr <= '0;
      idex_rd1   <= '0;
      idex_rd2   <= '0;
      idex_rd3   <= '0;
      idex_rs1   <= '0;
      idex_rs2   <= '0;
      r_flags    <= '0;
      idex_valid <= 1'b0;
    end else if (jmping || !stall) begin
      // Flush overrides stall: datapath loads, but the slot becomes a bubble.
      idex_pc    <= ifid_pc;
      idex_rd1   <= reg_rd1;
      idex_rd2   <= reg_rd2;
      idex_rd3   <= w_rd3;
      idex_rs1   <= reg_rs1;
      idex_rs2   <= reg_rs2;
      idex_instr <= jmping ? 16'h0000 : ifid_instr;
      r_flags    <= jmping ? flags_t'('0) : w_flags_valid;
      idex_valid <= jmping ? 1'b0 : ifid_valid;
    end
  end

  assign idex_has_br     = r_flags.br;
  assign idex_has_we     = r_flags.we;
  assign idex_has_mem    = r_flags.mem;
  assign idex_has_mem_we = r_flags.mem_we;
  assign exme_op         = idex_instr[15:11];

endmodule

// File: tb/tb_vmicro16_id_ex.sv
// Directed self-checking bench for vmicro16_id_ex with hand-computed vectors.
module tb_vmicro16_id_ex;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] ifid_pc, ifid_instr, reg_rd1, reg_rd2;
  logic        ifid_valid, stall, jmping;
  logic [2:0]  reg_rs1, reg_rs2, idex_rs1, idex_rs2;
  logic [15:0] idex_pc, idex_instr, idex_rd1, idex_rd2, idex_rd3;
  logic        idex_has_br, idex_has_we, idex_has_mem, idex_has_mem_we, idex_valid;
  logic [4:0]  exme_op;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vmicro16_id_ex dut (
    .clk(clk), .reset(reset),
    .ifid_pc(ifid_pc), .ifid_instr(ifid_instr), .ifid_valid(ifid_valid),
    .reg_rs1(reg_rs1), .reg_rs2(reg_rs2), .reg_rd1(reg_rd1), .reg_rd2(reg_rd2),
    .stall(stall), .jmping(jmping),
    .idex_pc(idex_pc), .idex_instr(idex_instr),
    .idex_rd1(idex_rd1), .idex_rd2(idex_rd2), .idex_rd3(idex_rd3),
    .idex_rs1(idex_rs1), .idex_rs2(idex_rs2),
    .idex_has_br(idex_has_br), .idex_has_we(idex_has_we),
    .idex_has_mem(idex_has_mem), .idex_has_mem_we(idex_has_mem_we),
    .idex_valid(idex_valid), .exme_op(exme_op)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Flags packed as {br, we, mem, mem_we}.
  task automatic check_flags(input string tag, input logic [3:0] exp);
    check(tag, {12'h000, idex_has_br, idex_has_we, idex_has_mem, idex_has_mem_we}, {12'h000, exp});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pc"}, idex_pc, 16'h0);
    check({tag, "_instr"}, idex_instr, 16'h0);
    check({tag, "_rd1"}, idex_rd1, 16'h0);
    check({tag, "_rd2"}, idex_rd2, 16'h0);
    check({tag, "_rd3"}, idex_rd3, 16'h0);
    check({tag, "_rs"}, {10'h0, idex_rs1, idex_rs2}, 16'h0);
    check_flags({tag, "_flags"}, 4'b0000);
    check({tag, "_valid"}, {15'h0, idex_valid}, 16'h0);
    check({tag, "_op"}, {11'h0, exme_op}, 16'h0);
  endtask

  task automatic drive(input logic [15:0] pc, input logic [15:0] instr, input logic valid,
                       input logic [15:0] rd1, input logic [15:0] rd2);
    ifid_pc = pc; ifid_instr = instr; ifid_valid = valid;
    reg_rd1 = rd1; reg_rd2 = rd2;
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; jmping = 1'b0;
    drive(16'h0, 16'h0, 1'b0, 16'h0, 16'h0);
    repeat (2) step();
    check_all_zero("rst");
    check("rst_rs", {10'h0, reg_rs1, reg_rs2}, 16'h0);
    reset = 1'b1;
    step();
    check_all_zero("idle");

    // MOVI r3, 0x85
    drive(16'h0010, 16'h2385, 1'b1, 16'h1234, 16'h5678);
    #1;
    check("movi_rs1", {13'h0, reg_rs1}, 16'd3);
    check("movi_rs2", {13'h0, reg_rs2}, 16'd4);
    step();
    check("movi_pc", idex_pc, 16'h0010);
    check("movi_instr", idex_instr, 16'h2385);
    check("movi_rd1", idex_rd1, 16'h1234);
    check("movi_rd2", idex_rd2, 16'h5678);
    check("movi_rd3", idex_rd3, 16'hFF85);
    check_flags("movi_flags", 4'b0100);
    check("movi_valid", {15'h0, idex_valid}, 16'h1);
    check("movi_op", {11'h0, exme_op}, 16'h0004);

    // LW then SW
    drive(16'h0012, 16'h095F, 1'b1, 16'hAAAA, 16'hBBBB);
    step();
    check("lw_rd3", idex_rd3, 16'hFFFF);
    check_flags("lw_flags", 4'b0110);
    check("lw_rs1", {13'h0, idex_rs1}, 16'd1);
    check("lw_rs2", {13'h0, idex_rs2}, 16'd2);
    check("lw_op", {11'h0, exme_op}, 16'h0001);
    drive(16'h0014, 16'h1143, 1'b1, 16'h0001, 16'h0002);
    step();
    check("sw_rd3", idex_rd3, 16'h0003);
    check_flags("sw_flags", 4'b0011);
    check("sw_pc", idex_pc, 16'h0014);

    // ALU with func 0x1F must zero-extend imm5
    drive(16'h0016, 16'h2A3F, 1'b1, 16'h0, 16'h0);
    step();
    check("alu_rd3", idex_rd3, 16'h001F);
    check_flags("alu_flags", 4'b0100);

    // BR valid, then same instruction as a bubble
    drive(16'h0018, 16'h4502, 1'b1, 16'h0, 16'h0);
    step();
    check_flags("br_flags", 4'b1000);
    check("br_rd3", idex_rd3, 16'h0002);
    ifid_valid = 1'b0;
    step();
    check_flags("brinv_flags", 4'b0000);
    check("brinv_valid", {15'h0, idex_valid}, 16'h0);
    check("brinv_instr", idex_instr, 16'h4502);

    // Stall for three edges
    drive(16'h0020, 16'h2385, 1'b1, 16'h1111, 16'h2222);
    step();
    drive(16'h0022, 16'h095F, 1'b1, 16'h3333, 16'h4444);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_instr", idex_instr, 16'h2385);
      check("stall_pc", idex_pc, 16'h0020);
      check("stall_rd1", idex_rd1, 16'h1111);
      check_flags("stall_flags", 4'b0100);
    end
    check("stall_rs_live", {13'h0, reg_rs1}, 16'd1);
    stall = 1'b0;
    step();
    check("unstall_instr", idex_instr, 16'h095F);
    check("unstall_rd3", idex_rd3, 16'hFFFF);
    check("unstall_rd1", idex_rd1, 16'h3333);
    check_flags("unstall_flags", 4'b0110);

    // Flush beats stall; datapath still loads
    drive(16'h0042, 16'h095F, 1'b1, 16'h5555, 16'h6666);
    stall = 1'b1; jmping = 1'b1;
    step();
    check("flush_valid", {15'h0, idex_valid}, 16'h0);
    check_flags("flush_flags", 4'b0000);
    check("flush_instr", idex_instr, 16'h0000);
    check("flush_op", {11'h0, exme_op}, 16'h0);
    check("flush_pc", idex_pc, 16'h0042);
    check("flush_rd1", idex_rd1, 16'h5555);
    jmping = 1'b0; stall = 1'b0;
    step();
    check("postflush_valid", {15'h0, idex_valid}, 16'h1);
    check("postflush_instr", idex_instr, 16'h095F);

    // Async reset, released while stalled
    #2 reset = 1'b0;
    #1;
    check_all_zero("async_rst");
    stall = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    step();
    check_all_zero("rst_stall");
    stall = 1'b0;
    step();
    check("rst_resume_instr", idex_instr, 16'h095F);
    check("rst_resume_valid", {15'h0, idex_valid}, 16'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
